// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: byte width and capture FSM encodings.
package serial_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } cap_state_e;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers; count, full and valid are registered.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_dat_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dat_o,
  output logic                  valid_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic                full_q, valid_q;
  logic                do_push, do_pop;

  // Full/empty decisions use the pre-edge registered flags, so a push at full is
  // dropped even when a pop lands on the same edge.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_CNT);
      valid_q  <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_dat_i;
  end

  assign dat_o   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign valid_o = valid_q;
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/serial_rx_fifo.sv
// Captures bytes from the serial receiver, acknowledges each once, and buffers them in a FIFO.
//   state       | meaning
//   ST_IDLE     | waiting for rx_ready; captures or drops the byte on the edge it is seen
//   ST_ACK      | rx_ready_rst high for this single cycle
//   ST_WAIT_LOW | holding until rx_ready falls so one byte is never captured twice
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = BYTE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    rx_dat,
  input  logic                rx_ready,
  output logic                rx_ready_rst,
  output logic [WIDTH-1:0]    m_dat,
  output logic                m_valid,
  input  logic                m_ack,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                overflow,
  input  logic                ovf_clr
);

  cap_state_e state_q, state_d;
  logic       ack_q;
  logic       ovf_q, ovf_d;
  logic       push, drop;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          push    = !full;
          drop    = full;
          state_d = ST_ACK;
        end
      end
      ST_ACK:      state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!rx_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // A drop on the same edge as a clear must leave the flag set.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ST_ACK);
      ovf_q   <= ovf_d;
    end
  end

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (rx_dat),
    .pop_i      (m_ack),
    .dat_o      (m_dat),
    .valid_o    (m_valid),
    .count_o    (count),
    .full_o     (full)
  );

  assign rx_ready_rst = ack_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo: inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_dat;
  logic       rx_ready;
  logic       rx_ready_rst;
  logic [7:0] m_dat;
  logic       m_valid;
  logic       m_ack;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;

  serial_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_dat       (rx_dat),
    .rx_ready     (rx_ready),
    .rx_ready_rst (rx_ready_rst),
    .m_dat        (m_dat),
    .m_valid      (m_valid),
    .m_ack        (m_ack),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte, expect its acknowledge on the first edge, then release rx_ready.
  task automatic send_byte(input logic [7:0] b);
    int lat;
    bit got;
    rx_dat   = b;
    rx_ready = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      lat++;
      if (rx_ready_rst) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_lat", 32'(lat), 32'd1);
    rx_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_one();
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
  endtask

  initial begin
    int acks;
    int maxc;
    logic [7:0] exp_b;

    rst = 1'b1; rx_dat = '0; rx_ready = 1'b0; m_ack = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_ack", 32'(rx_ready_rst), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    tick();

    // single byte
    rx_dat = 8'h41; rx_ready = 1'b1;
    tick();
    chk("single_ack", 32'(rx_ready_rst), 1);
    chk("single_valid", 32'(m_valid), 1);
    chk("single_dat", 32'(m_dat), 32'h41);
    chk("single_count", 32'(count), 1);
    rx_ready = 1'b0;
    tick();
    chk("single_ack_once", 32'(rx_ready_rst), 0);
    tick();
    pop_one();
    chk("single_pop_valid", 32'(m_valid), 0);
    chk("single_pop_count", 32'(count), 0);

    // rx_ready held high well past the acknowledge
    rx_dat = 8'h55; rx_ready = 1'b1;
    tick();
    chk("sticky_ack", 32'(rx_ready_rst), 1);
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rx_ready_rst) acks++;
    end
    chk("sticky_extra_acks", 32'(acks), 0);
    chk("sticky_count", 32'(count), 1);
    rx_ready = 1'b0;
    tick(); tick();
    pop_one();
    chk("sticky_empty", 32'(count), 0);

    // fill to 16 then overflow with a 17th byte
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i));
      if (i == 15) begin
        chk("fill_full", 32'(full), 1);
        chk("fill_count16", 32'(count), 16);
        chk("fill_no_ovf", 32'(overflow), 0);
      end
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(m_valid), 1);
      chk("drain_dat", 32'(m_dat), 32'(i));
      pop_one();
    end
    chk("drain_empty", 32'(m_valid), 0);
    chk("drain_not_full", 32'(full), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // full with a pop on the same edge as a new byte
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
    chk("fp_full", 32'(full), 1);
    rx_dat = 8'hEE; rx_ready = 1'b1; m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    chk("fp_ack", 32'(rx_ready_rst), 1);
    chk("fp_count", 32'(count), 15);
    chk("fp_ovf", 32'(overflow), 1);
    chk("fp_head", 32'(m_dat), 32'h21);
    rx_ready = 1'b0;
    tick(); tick();
    for (int i = 1; i < 16; i++) begin
      chk("fp_drain", 32'(m_dat), 32'h20 + 32'(i));
      pop_one();
    end
    chk("fp_empty", 32'(m_valid), 0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("fp_ovf_clr", 32'(overflow), 0);

    // continuous streaming with m_ack held high, across pointer wrap
    m_ack = 1'b1;
    exp_b = 8'h80;
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      rx_dat = 8'h80 + 8'(i); rx_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (k == 0) rx_ready = 1'b0;
        if (int'(count) > maxc) maxc = int'(count);
        if (m_valid) begin
          chk("wrap_dat", 32'(m_dat), 32'(exp_b));
          exp_b++;
        end
      end
    end
    m_ack = 1'b0;
    chk("wrap_popped", 32'(exp_b), 32'hA8);
    chk("wrap_maxc", 32'(maxc <= 2), 1);
    chk("wrap_ovf", 32'(overflow), 0);
    chk("wrap_empty", 32'(m_valid), 0);

    // async reset while in the acknowledge cycle with five entries stored
    for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i));
    rx_dat = 8'h64; rx_ready = 1'b1;
    tick();
    chk("ar_pre_ack", 32'(rx_ready_rst), 1);
    chk("ar_pre_count", 32'(count), 5);
    #2 rst = 1'b1;
    #1;
    chk("ar_ack", 32'(rx_ready_rst), 0);
    chk("ar_valid", 32'(m_valid), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_full", 32'(full), 0);
    chk("ar_ovf", 32'(overflow), 0);
    rx_dat = 8'h77;
    #1 rst = 1'b0;
    tick();
    chk("ar_cap_ack", 32'(rx_ready_rst), 1);
    chk("ar_cap_count", 32'(count), 1);
    chk("ar_cap_dat", 32'(m_dat), 32'h77);
    rx_ready = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
